// File: rtl/alu_pkg.sv
// ============================================================================
// Module : alu_pkg
// Brief  : Opcodes, flag bit positions, FSM states and digit-slice operations
//          shared by alu_serial and alu_digit. Optional macro: ALU_DAA_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_pkg;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_ADC = 4'd1;
  localparam logic [3:0] ALU_SUB = 4'd2;
  localparam logic [3:0] ALU_SBB = 4'd3;
  localparam logic [3:0] ALU_AND = 4'd4;
  localparam logic [3:0] ALU_XOR = 4'd5;
  localparam logic [3:0] ALU_OR  = 4'd6;
  localparam logic [3:0] ALU_CMP = 4'd7;
  localparam logic [3:0] ALU_INR = 4'd8;
  localparam logic [3:0] ALU_DCR = 4'd9;
  localparam logic [3:0] ALU_DAA = 4'd10;

  localparam int FLAG_C = 0;
  localparam int FLAG_A = 1;
  localparam int FLAG_Z = 2;
  localparam int FLAG_S = 3;
  localparam int FLAG_P = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    DG_NONE = 3'd0,
    DG_ADD  = 3'd1,
    DG_SUB  = 3'd2,
    DG_AND  = 3'd3,
    DG_OR   = 3'd4,
    DG_XOR  = 3'd5,
    DG_DAA  = 3'd6
  } dig_op_e;

  // INR/DCR reuse the add/sub slice with a forced carry-in of one.
  function automatic dig_op_e dig_op_of(input logic [3:0] op);
    dig_op_e d;
    d = DG_NONE;
    case (op)
      ALU_ADD, ALU_ADC, ALU_INR:          d = DG_ADD;
      ALU_SUB, ALU_SBB, ALU_CMP, ALU_DCR: d = DG_SUB;
      ALU_AND:                            d = DG_AND;
      ALU_OR:                             d = DG_OR;
      ALU_XOR:                            d = DG_XOR;
`ifdef ALU_DAA_EN
      ALU_DAA:                            d = DG_DAA;
`endif
      default:                            d = DG_NONE;
    endcase
    return d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_digit.sv
// ============================================================================
// Module : alu_digit
// Brief  : Combinational DIGIT-bit ALU slice, reused once per clock by
//          alu_serial. Decimal-adjust path present only with ALU_DAA_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_digit
  import alu_pkg::*;
#(
  parameter int DIGIT = 4
) (
  input  dig_op_e          op,
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] res,
  output logic             cout
);

  logic [DIGIT:0] w_sum;
  logic [DIGIT:0] w_dif;
`ifdef ALU_DAA_EN
  logic [DIGIT:0] w_daa;
`endif

  always_comb begin
    // Subtraction: the extra top bit becomes the borrow out.
    w_sum = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, cin};
    w_dif = {1'b0, a} - {1'b0, b} - {{DIGIT{1'b0}}, cin};
`ifdef ALU_DAA_EN
    // b[0] carries the force-correct flag (A for digit 0, C for digit 1).
    w_daa = {1'b0, a} + {{DIGIT{1'b0}}, cin};
    if ((w_daa > (DIGIT+1)'(9)) || b[0]) begin
      w_daa = w_daa + (DIGIT+1)'(6);
    end
`endif
    res  = '0;
    cout = 1'b0;
    case (op)
      DG_ADD:  {cout, res} = w_sum;
      DG_SUB:  {cout, res} = w_dif;
      DG_AND:  res = a & b;
      DG_OR:   res = a | b;
      DG_XOR:  res = a ^ b;
`ifdef ALU_DAA_EN
      DG_DAA:  {cout, res} = w_daa;
`endif
      default: begin
        res  = '0;
        cout = 1'b0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/alu_serial.sv
// ============================================================================
// Module : alu_serial
// Brief  : Digit-serial 8080-style ALU with internal C/A/Z/S/P flag register
//          and valid/ready handshakes. Optional macro: ALU_DAA_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_serial
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_dst,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic             out_c,
  output logic             out_a,
  output logic             out_z,
  output logic             out_s,
  output logic             out_p
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  if (WIDTH % DIGIT != 0) begin : g_width_check
    $error("alu_serial: WIDTH must be a multiple of DIGIT");
  end
`ifdef ALU_DAA_EN
  if (WIDTH != 8 || DIGIT != 4) begin : g_daa_check
    $error("alu_serial: ALU_DAA_EN requires WIDTH == 8 and DIGIT == 4");
  end
`endif

  state_e           state_q, state_d;
  logic [3:0]       op_q, op_d;
  dig_op_e          dop_q, dop_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, out_res_q, out_res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d, aux_q, aux_d;
  logic [4:0]       flags_q, flags_d;

  logic [DIGIT-1:0] w_dig_res;
  logic             w_dig_cout;
  logic [WIDTH-1:0] w_new_res;
  logic             w_aux;
  logic             w_def;

  alu_digit #(.DIGIT(DIGIT)) u_digit (
    .op   (dop_q),
    .a    (a_q[DIGIT-1:0]),
    .b    (b_q[DIGIT-1:0]),
    .cin  (carry_q),
    .res  (w_dig_res),
    .cout (w_dig_cout)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    dop_d     = dop_q;
    a_d       = a_q;
    b_d       = b_q;
    cnt_d     = cnt_q;
    carry_d   = carry_q;
    aux_d     = aux_q;
    res_d     = res_q;
    out_res_d = out_res_q;
    flags_d   = flags_q;
    w_def     = 1'b0;
    // New digit enters at the top so the last digit leaves the word aligned.
    w_new_res = (res_q >> DIGIT) | (WIDTH'(w_dig_res) << (WIDTH - DIGIT));
    w_aux     = (cnt_q == '0) ? w_dig_cout : aux_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = ST_RUN;
          op_d    = in_op;
          dop_d   = dig_op_of(in_op);
          cnt_d   = '0;
          a_d     = in_a;
          b_d     = in_dst;
          carry_d = 1'b0;
          case (in_op)
            ALU_ADC, ALU_SBB: carry_d = flags_q[FLAG_C];
            ALU_INR, ALU_DCR: begin
              a_d     = in_dst;
              b_d     = '0;
              carry_d = 1'b1;
            end
`ifdef ALU_DAA_EN
            ALU_DAA: b_d = WIDTH'(flags_q[FLAG_A]) | (WIDTH'(flags_q[FLAG_C]) << DIGIT);
`endif
            default: ;
          endcase
        end
      end

      ST_RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        carry_d = w_dig_cout;
        aux_d   = w_aux;
        res_d   = w_new_res;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(NDIG - 1)) begin
          state_d = ST_DONE;
          w_def   = 1'b1;
          case (op_q)
            ALU_ADD, ALU_ADC, ALU_SUB, ALU_SBB, ALU_CMP: begin
              flags_d[FLAG_C] = w_dig_cout;
              flags_d[FLAG_A] = w_aux;
              if (op_q != ALU_CMP) out_res_d = w_new_res;
            end
            ALU_INR, ALU_DCR: begin
              flags_d[FLAG_A] = w_aux;
              out_res_d       = w_new_res;
            end
            ALU_AND, ALU_OR, ALU_XOR: begin
              flags_d[FLAG_C] = 1'b0;
              flags_d[FLAG_A] = 1'b0;
              out_res_d       = w_new_res;
            end
`ifdef ALU_DAA_EN
            ALU_DAA: begin
              flags_d[FLAG_C] = flags_q[FLAG_C] | w_dig_cout;
              flags_d[FLAG_A] = w_aux;
              out_res_d       = w_new_res;
            end
`endif
            default: begin
              w_def     = 1'b0;
              out_res_d = '0;
            end
          endcase
          if (w_def) begin
            flags_d[FLAG_Z] = ~|w_new_res;
            flags_d[FLAG_S] = w_new_res[WIDTH-1];
            flags_d[FLAG_P] = ~^w_new_res;
          end
        end
      end

      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      op_q      <= '0;
      dop_q     <= DG_NONE;
      a_q       <= '0;
      b_q       <= '0;
      cnt_q     <= '0;
      carry_q   <= 1'b0;
      aux_q     <= 1'b0;
      res_q     <= '0;
      out_res_q <= '0;
      flags_q   <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      dop_q     <= dop_d;
      a_q       <= a_d;
      b_q       <= b_d;
      cnt_q     <= cnt_d;
      carry_q   <= carry_d;
      aux_q     <= aux_d;
      res_q     <= res_d;
      out_res_q <= out_res_d;
      flags_q   <= flags_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE) && !reset;
  assign out_valid = (state_q == ST_DONE);
  assign out_res   = out_res_q;
  assign out_c     = flags_q[FLAG_C];
  assign out_a     = flags_q[FLAG_A];
  assign out_z     = flags_q[FLAG_Z];
  assign out_s     = flags_q[FLAG_S];
  assign out_p     = flags_q[FLAG_P];

endmodule

`default_nettype wire

// File: tb/tb_alu_serial.sv
// ============================================================================
// Module : tb_alu_serial
// Brief  : Self-checking bench for alu_serial: directed vectors plus random
//          operations against a behavioural flag/result model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_serial;
  import alu_pkg::*;

  localparam int W     = 8;
  localparam int D     = 4;
  localparam int NDIG  = W / D;
  localparam int DMASK = (1 << D) - 1;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   in_op;
  logic [W-1:0] in_a;
  logic [W-1:0] in_dst;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_res;
  logic         out_c, out_a, out_z, out_s, out_p;
  logic [4:0]   flags;

  assign flags = {out_c, out_a, out_z, out_s, out_p};

  alu_serial #(.WIDTH(W), .DIGIT(D)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_dst    (in_dst),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_c     (out_c),
    .out_a     (out_a),
    .out_z     (out_z),
    .out_s     (out_s),
    .out_p     (out_p)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference state: last result and flag register.
  logic [W-1:0] m_res;
  logic         m_c, m_a, m_z, m_s, m_p;

  function automatic logic [4:0] m_flags();
    return {m_c, m_a, m_z, m_s, m_p};
  endfunction

  task automatic model_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] d);
    logic [W:0]   full;
    logic [W-1:0] r;
    logic         nc, na, known, is_cmp, cin;
    int           lo_a, lo_d, v;
    known  = 1'b1;
    is_cmp = 1'b0;
    nc     = 1'b0;
    na     = 1'b0;
    r      = '0;
    lo_a   = int'(a) & DMASK;
    lo_d   = int'(d) & DMASK;
    case (op)
      ALU_ADD, ALU_ADC: begin
        cin  = (op == ALU_ADC) ? m_c : 1'b0;
        full = {1'b0, a} + {1'b0, d} + (W+1)'(cin);
        r    = full[W-1:0];
        nc   = full[W];
        na   = (lo_a + lo_d + int'(cin)) > DMASK;
      end
      ALU_SUB, ALU_SBB, ALU_CMP: begin
        cin    = (op == ALU_SBB) ? m_c : 1'b0;
        full   = {1'b0, a} - {1'b0, d} - (W+1)'(cin);
        r      = full[W-1:0];
        nc     = full[W];
        na     = lo_a < (lo_d + int'(cin));
        is_cmp = (op == ALU_CMP);
      end
      ALU_INR: begin
        r  = d + W'(1);
        nc = m_c;
        na = (lo_d == DMASK);
      end
      ALU_DCR: begin
        r  = d - W'(1);
        nc = m_c;
        na = (lo_d == 0);
      end
      ALU_AND: r = a & d;
      ALU_OR:  r = a | d;
      ALU_XOR: r = a ^ d;
`ifdef ALU_DAA_EN
      ALU_DAA: begin
        v = int'(a);
        if (lo_a > 9 || m_a) begin
          v  = v + 6;
          na = (lo_a + 6) > 15;
        end
        if ((v >> 4) > 9 || m_c) v = v + 'h60;
        nc = m_c || (v > 255);
        r  = W'(v);
      end
`endif
      default: known = 1'b0;
    endcase
    if (!known) begin
      m_res = '0;
    end else begin
      if (!is_cmp) m_res = r;
      m_c = nc;
      m_a = na;
      m_z = (r == '0);
      m_s = r[W-1];
      m_p = ~^r;
    end
  endtask

  // One complete transaction: accept, latency, result, back-pressure, release.
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] d,
                        input int hold);
    int lat;
    int guard;
    @(negedge clk);
    in_op    = op;
    in_a     = a;
    in_dst   = d;
    in_valid = 1'b1;
    guard    = 0;
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk($sformatf("accept op%0d", op), in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk($sformatf("latency op%0d", op), lat, NDIG);
    model_op(op, a, d);
    chk($sformatf("res op%0d a=%0h d=%0h", op, a, d), out_res, m_res);
    chk($sformatf("flags op%0d a=%0h d=%0h", op, a, d), flags, m_flags());
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_op    = 4'($urandom);
      in_a     = W'($urandom);
      in_dst   = W'($urandom);
      chk("hold in_ready", in_ready, 0);
      chk("hold out_valid", out_valid, 1);
      chk("hold res", out_res, m_res);
      chk("hold flags", flags, m_flags());
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_op     = '0;
    in_a      = '0;
    in_dst    = '0;
    out_ready = 1'b0;
    m_res = '0; m_c = 0; m_a = 0; m_z = 0; m_s = 0; m_p = 0;

    repeat (2) @(negedge clk);
    chk("reset in_ready", in_ready, 0);
    chk("reset out_valid", out_valid, 0);
    chk("reset res", out_res, 0);
    chk("reset flags", flags, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("post-reset in_ready", in_ready, 1);

    // Directed vectors; flags packed as {C,A,Z,S,P}.
    run_op(ALU_ADD, 8'h3A, 8'hC6, 0);
    chk("ADD 3A+C6 res", out_res, 8'h00);
    chk("ADD 3A+C6 flags", flags, 5'b11101);

    run_op(ALU_SUB, 8'h00, 8'h01, 0);
    chk("SUB 00-01 res", out_res, 8'hFF);
    chk("SUB 00-01 flags", flags, 5'b11011);

    run_op(ALU_SBB, 8'h05, 8'h01, 0);
    chk("SBB 05-01-C res", out_res, 8'h03);
    chk("SBB 05-01-C flags", flags, 5'b00001);

    run_op(ALU_ADD, 8'hFF, 8'h01, 0);
    chk("ADD FF+01 C", out_c, 1);
    run_op(ALU_INR, 8'h55, 8'hFF, 0);
    chk("INR FF res", out_res, 8'h00);
    chk("INR FF flags", flags, 5'b11101);

    run_op(ALU_CMP, 8'h10, 8'h20, 0);
    chk("CMP res unchanged", out_res, 8'h00);
    chk("CMP flags", flags, 5'b10011);

    run_op(ALU_AND, 8'hFF, 8'h0F, 0);
    chk("AND res", out_res, 8'h0F);
    chk("AND flags", flags, 5'b00001);
    run_op(ALU_DAA, 8'h9B, 8'h00, 0);
`ifdef ALU_DAA_EN
    chk("DAA 9B res", out_res, 8'h01);
    chk("DAA 9B flags", flags, 5'b11000);
`else
    chk("DAA undefined res", out_res, 8'h00);
    chk("DAA undefined flags", flags, 5'b00001);
`endif

    // Back-pressure: result held, requests while busy dropped.
    run_op(ALU_ADD, 8'h12, 8'h34, 5);
    chk("backpressure res", out_res, 8'h46);
    for (int i = 0; i < NDIG + 2; i++) begin
      @(negedge clk);
      chk("not queued out_valid", out_valid, 0);
    end
    chk("idle in_ready", in_ready, 1);

    // Reset mid-operation.
    @(negedge clk);
    in_op = ALU_ADD; in_a = 8'h01; in_dst = 8'h01; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("mid-run reset in_ready", in_ready, 0);
    chk("mid-run reset out_valid", out_valid, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < NDIG + 2; i++) begin
      @(negedge clk);
      chk("after reset out_valid", out_valid, 0);
    end
    chk("after reset flags", flags, 0);
    chk("after reset res", out_res, 0);
    chk("after reset in_ready", in_ready, 1);
    m_res = '0; m_c = 0; m_a = 0; m_z = 0; m_s = 0; m_p = 0;

    // Random operations, including undefined opcodes and back-pressure.
    for (int k = 0; k < 200; k++) begin
      run_op(4'($urandom_range(0, 15)), W'($urandom), W'($urandom), $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
